// File: rtl/fp_addsub_seq.sv
// Sequential IEEE-754 single-precision adder/subtractor (IDLE/ALIGN/ADD/NORM/DONE); optional RNE rounding via FP_SEQ_RNE_EN.
// Latency: out_valid rises k+4 cycles after acceptance, k = number of NORM shift steps (0 for zero sum).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, one idle cycle after each DONE handshake.
module fp_addsub_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        overflow,
   output logic        busy
);

   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

   state_t      r_state, w_next;
   logic [31:0] r_a, r_b;
   logic        r_nan, r_sign, r_sign_s;
   logic [9:0]  r_exp;
   logic [26:0] r_mbig, r_msml;     // {hidden, frac[22:0], guard, round, sticky}
   logic [27:0] r_sum;              // extra top bit catches the carry out
   logic        r_out_vld, r_ovf;
   logic [31:0] r_result;

   // ---- ALIGN datapath: order operands by magnitude, shift the smaller one ----
   logic [7:0]  w_ea, w_eb, w_e_big, w_e_sml, w_diff;
   logic [23:0] w_ma, w_mb, w_m_big, w_m_sml;
   logic        w_swap, w_s_big, w_s_sml, w_lost;
   logic [26:0] w_ext, w_shifted, w_mask, w_sml_al;

   assign w_ea    = r_a[30:23];
   assign w_eb    = r_b[30:23];
   // exponent 0 inputs are flushed to zero
   assign w_ma    = (w_ea != 8'd0) ? {1'b1, r_a[22:0]} : 24'd0;
   assign w_mb    = (w_eb != 8'd0) ? {1'b1, r_b[22:0]} : 24'd0;
   assign w_swap  = {w_eb, w_mb} > {w_ea, w_ma};
   assign w_e_big = w_swap ? w_eb : w_ea;
   assign w_e_sml = w_swap ? w_ea : w_eb;
   assign w_m_big = w_swap ? w_mb : w_ma;
   assign w_m_sml = w_swap ? w_ma : w_mb;
   assign w_s_big = w_swap ? r_b[31] : r_a[31];
   assign w_s_sml = w_swap ? r_a[31] : r_b[31];
   assign w_diff  = w_e_big - w_e_sml;
   assign w_ext     = {w_m_sml, 3'b000};
   assign w_shifted = w_ext >> w_diff;
   assign w_mask    = (27'd1 << w_diff) - 27'd1;
   assign w_lost    = |(w_ext & w_mask);
   // shifts of 26 or more leave nothing but the sticky bit
   assign w_sml_al  = (w_diff >= 8'd26) ? {26'd0, |w_m_sml}
                                        : {w_shifted[26:1], w_shifted[0] | w_lost};

   // ---- ADD datapath: magnitude add or subtract (big >= small, so no borrow) ----
   logic [27:0] w_sum;
   assign w_sum = (r_sign == r_sign_s) ? ({1'b0, r_mbig} + {1'b0, r_msml})
                                       : ({1'b0, r_mbig} - {1'b0, r_msml});

   // ---- NORM decision and final packing ----
   logic        w_zero, w_norm_done, w_rnd_up, w_ovf;
   logic [23:0] w_frac_r;
   logic [22:0] w_frac_f;
   logic [9:0]  w_exp_f;
   logic [31:0] w_res;

   assign w_zero      = (r_sum == 28'd0);
   assign w_norm_done = r_nan | w_zero | (~r_sum[27] & (r_sum[26] | (r_exp == 10'd0)));
`ifdef FP_SEQ_RNE_EN
   assign w_rnd_up    = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
`else
   assign w_rnd_up    = 1'b0;
`endif
   assign w_frac_r    = {1'b0, r_sum[25:3]} + {23'd0, w_rnd_up};
   // a rounding carry bumps the exponent and clears the fraction
   assign w_exp_f     = r_exp + {9'd0, w_frac_r[23]};
   assign w_frac_f    = w_frac_r[23] ? 23'd0 : w_frac_r[22:0];
   assign w_ovf       = ~r_nan & ~w_zero & (w_exp_f >= 10'd255);
   assign w_res       = r_nan  ? 32'h7FC0_0000 :
                        w_zero ? 32'h0000_0000 :
                        w_ovf  ? {r_sign, 8'hFF, 23'd0} :
                                 {r_sign, w_exp_f[7:0], w_frac_f};

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state and handshake outputs
   always_comb begin
      w_next   = r_state;
      in_ready = 1'b0;
      busy     = 1'b1;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) w_next = S_ALIGN;
         end
         S_ALIGN: w_next = S_ADD;
         S_ADD:   w_next = S_NORM;
         S_NORM:  if (w_norm_done) w_next = S_DONE;
         S_DONE:  if (r_out_vld && out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath registers advanced per state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a       <= 32'd0;
         r_b       <= 32'd0;
         r_nan     <= 1'b0;
         r_sign    <= 1'b0;
         r_sign_s  <= 1'b0;
         r_exp     <= 10'd0;
         r_mbig    <= 27'd0;
         r_msml    <= 27'd0;
         r_sum     <= 28'd0;
         r_out_vld <= 1'b0;
         r_result  <= 32'd0;
         r_ovf     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_a   <= a;
               r_b   <= {b[31] ^ op, b[30:0]};
               r_nan <= (a[30:23] == 8'hFF) | (b[30:23] == 8'hFF);
            end
            S_ALIGN: begin
               r_mbig   <= {w_m_big, 3'b000};
               r_msml   <= w_sml_al;
               r_exp    <= {2'b00, w_e_big};
               r_sign   <= w_s_big;
               r_sign_s <= w_s_sml;
            end
            S_ADD: begin
               r_sum <= w_sum;
               if (w_sum == 28'd0) r_sign <= 1'b0;
            end
            S_NORM: begin
               if (w_norm_done) begin
                  r_result <= w_res;
                  r_ovf    <= w_ovf;
               end else if (r_sum[27]) begin
                  r_sum <= {1'b0, r_sum[27:2], r_sum[1] | r_sum[0]};
                  r_exp <= r_exp + 10'd1;
               end else begin
                  r_sum <= {r_sum[26:0], 1'b0};
                  r_exp <= r_exp - 10'd1;
               end
            end
            S_DONE: begin
               // out_valid rises one cycle into DONE and drops on the handshake
               if (!r_out_vld)     r_out_vld <= 1'b1;
               else if (out_ready) r_out_vld <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign out_valid = r_out_vld;
   assign result    = r_result;
   assign overflow  = r_ovf;

endmodule
